// File: rtl/vip_pkg.sv
// Shared types and helpers for the VIP grey-level filter blocks.
package vip_pkg;

  localparam int unsigned LAT   = 4;
  localparam int unsigned MAX_W = 32;

  typedef enum logic {
    MODE_MIN = 1'b0,
    MODE_MAX = 1'b1
  } mode_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] cmp_sel(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input mode_e mode);
    if (mode == MODE_MIN) return (a <= b) ? a : b;
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/vip_line_buffer_taps.sv
// Cascaded line-buffer RAMs: tap k holds the pixel k+1 lines above the write
// position, registered on every in-range write.
module vip_line_buffer_taps #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned NTAP   = 2,
  parameter int unsigned AW     = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en_i,
  input  logic [AW-1:0]               addr_i,
  input  logic [DATA_W-1:0]           din_i,
  output logic [NTAP-1:0][DATA_W-1:0] taps_o
);

  logic [DATA_W-1:0]           mem_q [NTAP][DEPTH];
  logic [NTAP-1:0][DATA_W-1:0] tap_q;

  // Read-before-write at one address: each RAM inherits the line the one above it gives up.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[0][addr_i] <= din_i;
      for (int unsigned k = 1; k < NTAP; k++) begin
        mem_q[k][addr_i] <= mem_q[k-1][addr_i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q <= '0;
    end else if (wr_en_i) begin
      for (int unsigned k = 0; k < NTAP; k++) begin
        tap_q[k] <= mem_q[k][addr_i];
      end
    end
  end

  assign taps_o = tap_q;

endmodule

// File: rtl/vip_gray_rank_filter_nxn.sv
// Streamed WINxWIN grey min/max (erode/dilate) filter with a causal window,
// top/left edge replication, bypass, and fixed LAT-cycle latency.
module vip_gray_rank_filter_nxn
  import vip_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned IMG_HDISP = 1024,
  parameter int unsigned IMG_VDISP = 768,
  parameter int unsigned WIN       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_mode,
  input  logic              cfg_bypass,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_Y,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_Y,
  output logic              line_overrun
);

  localparam int unsigned NT = WIN - 1;
  localparam int unsigned AW = (clog2(IMG_HDISP) > 0) ? clog2(IMG_HDISP) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = (clog2(IMG_VDISP) > 0) ? clog2(IMG_VDISP) : 1;
  localparam int unsigned SW = clog2(WIN);

  if (!(WIN == 3 || WIN == 5)) begin : g_bad_win
    $error("vip_gray_rank_filter_nxn: WIN must be 3 or 5");
  end
  if (DATA_W > MAX_W) begin : g_bad_width
    $error("vip_gray_rank_filter_nxn: DATA_W too wide");
  end

  function automatic logic [DATA_W-1:0] red(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input mode_e m);
    return DATA_W'(cmp_sel(MAX_W'(a), MAX_W'(b), m));
  endfunction

  mode_e                     mode_q;
  logic                      bypass_q, ovf_q, ovf_d, vs_prev_q, href_prev_q;
  logic                      vs_rise, href_fall, in_range;
  logic [CW-1:0]             col_cnt_q, col_cnt_d;
  logic [RW-1:0]             row_cnt_q, row_cnt_d;
  logic [LAT-1:0]            vs_dly_q, hr_dly_q, ck_dly_q;
  logic [NT-1:0][DATA_W-1:0] taps;
  logic [SW-1:0]             rsel_d, rsel1_q;
  logic [DATA_W-1:0]         pix1_q, pix2_q, pix3_q, colres_d, colres2_q;
  logic [DATA_W-1:0]         hres_d, res3_q, post_y_q;
  logic                      first1_q, first2_q, raw1_q, raw2_q, raw3_q;
  logic [NT-1:0][DATA_W-1:0] hreg_q;

  always_comb begin
    vs_rise   = per_frame_vsync & ~vs_prev_q;
    href_fall = href_prev_q & ~per_frame_href;
    in_range  = col_cnt_q < CW'(IMG_HDISP);
    col_cnt_d = col_cnt_q;
    if (href_fall) col_cnt_d = '0;
    else if (per_frame_clken && col_cnt_q != '1) col_cnt_d = col_cnt_q + 1'b1;
    row_cnt_d = row_cnt_q;
    if (vs_rise) row_cnt_d = '0;
    else if (href_fall && row_cnt_q != RW'(IMG_VDISP - 1)) row_cnt_d = row_cnt_q + 1'b1;
    ovf_d = vs_rise ? 1'b0 : ovf_q;
    if (per_frame_clken && !in_range) ovf_d = 1'b1;
    // Taps above the current row are dropped; they would replicate row 0, already in the set.
    rsel_d = (32'(row_cnt_q) >= NT) ? SW'(NT) : SW'(row_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      mode_q      <= MODE_MIN;
      bypass_q    <= 1'b0;
      vs_dly_q    <= '0;
      hr_dly_q    <= '0;
      ck_dly_q    <= '0;
    end else begin
      vs_prev_q   <= per_frame_vsync;
      href_prev_q <= per_frame_href;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      ovf_q       <= ovf_d;
      if (vs_rise) begin
        mode_q   <= mode_e'(cfg_mode);
        bypass_q <= cfg_bypass;
      end
      vs_dly_q <= {vs_dly_q[LAT-2:0], per_frame_vsync};
      hr_dly_q <= {hr_dly_q[LAT-2:0], per_frame_href};
      ck_dly_q <= {ck_dly_q[LAT-2:0], per_frame_clken};
    end
  end

  vip_line_buffer_taps #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_HDISP),
    .NTAP   (NT),
    .AW     (AW)
  ) u_taps (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en_i (per_frame_clken & in_range),
    .addr_i  (col_cnt_q[AW-1:0]),
    .din_i   (per_img_Y),
    .taps_o  (taps)
  );

  always_comb begin
    colres_d = pix1_q;
    for (int unsigned j = 1; j < WIN; j++) begin
      if (j <= 32'(rsel1_q)) colres_d = red(colres_d, taps[j-1], mode_q);
    end
    hres_d = colres2_q;
    if (!first2_q) begin
      for (int unsigned i = 0; i < NT; i++) hres_d = red(hres_d, hreg_q[i], mode_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix1_q    <= '0;
      first1_q  <= 1'b0;
      raw1_q    <= 1'b0;
      rsel1_q   <= '0;
      pix2_q    <= '0;
      colres2_q <= '0;
      first2_q  <= 1'b0;
      raw2_q    <= 1'b0;
      pix3_q    <= '0;
      res3_q    <= '0;
      raw3_q    <= 1'b0;
      hreg_q    <= '0;
      post_y_q  <= '0;
    end else begin
      if (per_frame_clken) begin
        pix1_q   <= per_img_Y;
        first1_q <= (col_cnt_q == '0);
        raw1_q   <= !in_range;
        rsel1_q  <= rsel_d;
      end
      if (ck_dly_q[0]) begin
        pix2_q    <= pix1_q;
        colres2_q <= colres_d;
        first2_q  <= first1_q;
        raw2_q    <= raw1_q;
      end
      if (ck_dly_q[1]) begin
        pix3_q    <= pix2_q;
        res3_q    <= hres_d;
        raw3_q    <= raw2_q;
        hreg_q[0] <= colres2_q;
        for (int unsigned i = 1; i < NT; i++) begin
          hreg_q[i] <= first2_q ? colres2_q : hreg_q[i-1];
        end
      end
      if (ck_dly_q[2]) post_y_q <= (bypass_q || raw3_q) ? pix3_q : res3_q;
    end
  end

  assign post_frame_vsync = vs_dly_q[LAT-1];
  assign post_frame_href  = hr_dly_q[LAT-1];
  assign post_frame_clken = ck_dly_q[LAT-1];
  assign post_img_Y       = post_y_q;
  assign line_overrun     = ovf_q;

endmodule
